wb_stage: RTL and testbench

- Write-back end of the register-file write interface: the M/W pipeline register plus retire control.
- Captures memory-stage results and drives destE/destM/valE/valM into the register file, which commits them on CLK.
- Gates writes by instruction status and enters a terminal halted state on the first exceptional status.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 127 ++++++++++++
 tb/tb_wb_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: M/W pipeline register, register-file write gating, halt on exceptional status, retire counter.
// One-cycle write latency; W_stall holds W, W_bubble inserts a bubble, and halting freezes everything until reset.
module wb_stage #(
   parameter int DATA_WID = 64,
   parameter int CNT_WID  = 32
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [2:0]          m_stat,
   input  logic [3:0]          m_icode,
   input  logic [DATA_WID-1:0] m_valE,
   input  logic [DATA_WID-1:0] m_valM,
   input  logic [3:0]          m_dstE,
   input  logic [3:0]          m_dstM,
   input  logic                W_stall,
   input  logic                W_bubble,
   output logic [3:0]          destE,
   output logic [3:0]          destM,
   output logic [DATA_WID-1:0] valE,
   output logic [DATA_WID-1:0] valM,
   output logic [3:0]          W_icode,
   output logic [2:0]          W_stat,
   output logic                halted,
   output logic [2:0]          final_stat,
   output logic [CNT_WID-1:0]  retired
);

   localparam logic [2:0] STAT_BUB = 3'd0;
   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [3:0] RNONE     = 4'hF;

   typedef enum logic {S_RUN, S_HALTED} state_t;

   state_t              state_q, state_d;
   logic [2:0]          w_stat_q, w_stat_d;
   logic [3:0]          w_icode_q, w_icode_d;
   logic [3:0]          w_dste_q, w_dste_d;
   logic [3:0]          w_dstm_q, w_dstm_d;
   logic [DATA_WID-1:0] w_vale_q, w_vale_d;
   logic [DATA_WID-1:0] w_valm_q, w_valm_d;
   logic [2:0]          final_stat_q, final_stat_d;
   logic [CNT_WID-1:0]  retired_q, retired_d;
   logic                w_exc;
   logic                wr_en;

   assign w_exc = (w_stat_q == STAT_HLT) || (w_stat_q == STAT_ADR) || (w_stat_q == STAT_INS);

   always_comb begin
      state_d      = state_q;
      w_stat_d     = w_stat_q;
      w_icode_d    = w_icode_q;
      w_dste_d     = w_dste_q;
      w_dstm_d     = w_dstm_q;
      w_vale_d     = w_vale_q;
      w_valm_d     = w_valm_q;
      final_stat_d = final_stat_q;
      retired_d    = retired_q;
      if (state_q == S_RUN) begin
         // An exceptional instruction halts regardless of stall and keeps W frozen on itself.
         if (w_exc) begin
            state_d      = S_HALTED;
            final_stat_d = w_stat_q;
         end else begin
            if ((w_stat_q == STAT_AOK) && !W_stall)
               retired_d = retired_q + 1'b1;
            if (!W_stall) begin
               if (W_bubble) begin
                  w_stat_d  = STAT_BUB;
                  w_icode_d = ICODE_NOP;
                  w_dste_d  = RNONE;
                  w_dstm_d  = RNONE;
                  w_vale_d  = '0;
                  w_valm_d  = '0;
               end else begin
                  w_stat_d  = m_stat;
                  w_icode_d = m_icode;
                  w_dste_d  = m_dstE;
                  w_dstm_d  = m_dstM;
                  w_vale_d  = m_valE;
                  w_valm_d  = m_valM;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q      <= S_RUN;
         w_stat_q     <= STAT_BUB;
         w_icode_q    <= ICODE_NOP;
         w_dste_q     <= RNONE;
         w_dstm_q     <= RNONE;
         w_vale_q     <= '0;
         w_valm_q     <= '0;
         final_stat_q <= STAT_AOK;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         w_stat_q     <= w_stat_d;
         w_icode_q    <= w_icode_d;
         w_dste_q     <= w_dste_d;
         w_dstm_q     <= w_dstm_d;
         w_vale_q     <= w_vale_d;
         w_valm_q     <= w_valm_d;
         final_stat_q <= final_stat_d;
         retired_q    <= retired_d;
      end
   end

   // Equal destinations pass through untouched; the register file resolves M-port priority.
   assign wr_en      = (state_q == S_RUN) && (w_stat_q == STAT_AOK);
   assign destE      = wr_en ? w_dste_q : RNONE;
   assign destM      = wr_en ? w_dstm_q : RNONE;
   assign valE       = w_vale_q;
   assign valM       = w_valm_q;
   assign W_icode    = w_icode_q;
   assign W_stat     = w_stat_q;
   assign halted     = (state_q == S_HALTED);
   assign final_stat = final_stat_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: instruction-level model compared every cycle, plus hand-computed directed checks.
module tb_wb_stage;
   localparam int DW = 64;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [2:0]    m_stat;
   logic [3:0]    m_icode;
   logic [DW-1:0] m_valE, m_valM;
   logic [3:0]    m_dstE, m_dstM;
   logic          W_stall, W_bubble;
   logic [3:0]    destE, destM;
   logic [DW-1:0] valE, valM;
   logic [3:0]    W_icode;
   logic [2:0]    W_stat;
   logic          halted;
   logic [2:0]    final_stat;
   logic [CW-1:0] retired;

   wb_stage #(.DATA_WID(DW), .CNT_WID(CW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
      .m_dstE(m_dstE), .m_dstM(m_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
      .destE(destE), .destM(destM), .valE(valE), .valM(valM),
      .W_icode(W_icode), .W_stat(W_stat), .halted(halted),
      .final_stat(final_stat), .retired(retired)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Instruction-level model: the instruction sitting in W, plus halt and retire bookkeeping.
   typedef struct {
      logic [2:0]    stat;
      logic [3:0]    icode, dstE, dstM;
      logic [DW-1:0] valE, valM;
   } instr_t;

   instr_t     mw;
   bit         m_halted;
   logic [2:0] m_fstat;
   int         m_ret;
   bit         model_ok = 0;

   function automatic instr_t bubble_instr();
      instr_t b;
      b.stat = 3'd0; b.icode = 4'h1; b.dstE = 4'hF; b.dstM = 4'hF; b.valE = '0; b.valM = '0;
      return b;
   endfunction

   always @(posedge CLK) begin
      if (!RST_N) begin
         mw = bubble_instr(); m_halted = 0; m_fstat = 3'd1; m_ret = 0; model_ok = 1;
      end else if (model_ok && !m_halted) begin
         if (mw.stat inside {3'd2, 3'd3, 3'd4}) begin
            m_halted = 1;
            m_fstat  = mw.stat;
         end else begin
            if (mw.stat == 3'd1 && !W_stall) m_ret = (m_ret + 1) % (1 << CW);
            if (!W_stall) begin
               if (W_bubble) mw = bubble_instr();
               else begin
                  mw.stat = m_stat; mw.icode = m_icode; mw.dstE = m_dstE; mw.dstM = m_dstM;
                  mw.valE = m_valE; mw.valM = m_valM;
               end
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (model_ok) begin
         automatic bit wr = !m_halted && mw.stat == 3'd1;
         chk("m_destE", destE, wr ? mw.dstE : 4'hF);
         chk("m_destM", destM, wr ? mw.dstM : 4'hF);
         chk("m_valE", valE, mw.valE);
         chk("m_valM", valM, mw.valM);
         chk("m_W_icode", W_icode, mw.icode);
         chk("m_W_stat", W_stat, mw.stat);
         chk("m_halted", halted, m_halted);
         chk("m_final_stat", final_stat, m_fstat);
         chk("m_retired", retired, m_ret[CW-1:0]);
      end
   end

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                        input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
      m_stat = st; m_icode = ic; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
   endtask

   initial begin
      RST_N = 0; W_stall = 0; W_bubble = 0;
      drive(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick(); tick();
      RST_N = 1;
      chk("rst_W_stat", W_stat, 3'd0);
      chk("rst_W_icode", W_icode, 4'h1);
      chk("rst_destE", destE, 4'hF);
      chk("rst_halted", halted, 1'b0);
      chk("rst_final_stat", final_stat, 3'd1);
      chk("rst_retired", retired, 4'd0);

      // Basic write: visible one edge after load, retired one edge later
      drive(3'd1, 4'h6, 4'h3, 4'hF, 64'h1234, 64'h0);
      tick();
      chk("wr_destE", destE, 4'h3);
      chk("wr_valE", valE, 64'h1234);
      chk("wr_destM", destM, 4'hF);
      chk("wr_ret0", retired, 4'd0);
      drive(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      chk("wr_ret1", retired, 4'd1);

      // Stall for 3 cycles: write repeats, counted once on release
      drive(3'd1, 4'h2, 4'h7, 4'hF, 64'h77, 64'h0);
      tick();
      W_stall = 1;
      drive(3'd1, 4'h3, 4'h9, 4'h9, 64'h99, 64'h98);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_destE", destE, 4'h7);
         chk("stall_ret", retired, 4'd1);
      end
      W_stall = 0;
      drive(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      chk("stall_rel_ret", retired, 4'd2);

      // Stall beats bubble; bubble alone empties W without counting a bubble
      drive(3'd1, 4'h6, 4'h8, 4'hF, 64'h88, 64'h0);
      tick();
      W_stall = 1; W_bubble = 1;
      tick();
      chk("sb_W_stat", W_stat, 3'd1);
      chk("sb_destE", destE, 4'h8);
      W_stall = 0;
      tick();
      chk("bub_W_stat", W_stat, 3'd0);
      chk("bub_destE", destE, 4'hF);
      chk("bub_ret", retired, 4'd3);
      tick();
      chk("bub_ret2", retired, 4'd3);
      W_bubble = 0;

      // AOK, ADR, AOK: ADR halts, writes nothing, third never enters W
      drive(3'd1, 4'h6, 4'h2, 4'hF, 64'h22, 64'h0);
      tick();
      chk("seq_destE2", destE, 4'h2);
      drive(3'd3, 4'h5, 4'hF, 4'h5, 64'h0, 64'h55);
      tick();
      chk("seq_adr_destM", destM, 4'hF);
      chk("seq_ret", retired, 4'd4);
      drive(3'd1, 4'h6, 4'h6, 4'hF, 64'h66, 64'h0);
      tick();
      chk("seq_halted", halted, 1'b1);
      chk("seq_final", final_stat, 3'd3);
      tick();
      chk("seq_W_stat", W_stat, 3'd3);
      chk("seq_ret_frozen", retired, 4'd4);

      RST_N = 0; tick(); RST_N = 1;
      chk("rst2_halted", halted, 1'b0);
      chk("rst2_retired", retired, 4'd0);

      // HLT with inputs toggling, then reset while stalled
      drive(3'd2, 4'h0, 4'hF, 4'hF, 64'hABCD, 64'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         W_stall = i[0]; W_bubble = i[1];
         drive(3'd1, 4'(i + 2), 4'(i), 4'(i + 1), 64'(i * 17), 64'(i * 3));
         tick();
         chk("hlt_halted", halted, 1'b1);
         chk("hlt_final", final_stat, 3'd2);
         chk("hlt_valE", valE, 64'hABCD);
      end
      W_stall = 1; W_bubble = 0;
      RST_N = 0; tick(); RST_N = 1;
      chk("rst3_halted", halted, 1'b0);
      chk("rst3_retired", retired, 4'd0);
      chk("rst3_W_stat", W_stat, 3'd0);
      W_stall = 0;

      // Counter wrap with a 4-bit counter: 16 retirements return it to 0
      drive(3'd1, 4'h6, 4'h1, 4'hF, 64'h1, 64'h0);
      for (int i = 0; i < 16; i++) tick();
      chk("wrap_15", retired, 4'd15);
      drive(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      chk("wrap_0", retired, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
